// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control FSM.
// Sequences the shared datapath and counts retired instructions.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        pc_write,
  output logic        branch,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic [3:0]  alu_control,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1100;
  localparam logic [3:0] ALU_SRL = 4'b1101;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_count;
  logic        w_retire;
  logic        w_funct_ok;
  logic [3:0]  w_r_alu;
  logic        w_is_mem;
  logic        w_is_lw;
  logic        w_is_r;
  logic        w_is_beq;
  logic        w_is_addi;
  logic        w_is_j;

  assign w_is_lw   = (opcode == 6'b100011);
  assign w_is_mem  = w_is_lw || (opcode == 6'b101011);
  assign w_is_r    = (opcode == 6'b000000);
  assign w_is_beq  = (opcode == 6'b000100);
  assign w_is_addi = (opcode == 6'b001000);
  assign w_is_j    = (opcode == 6'b000010);

  always_comb begin
    w_funct_ok = 1'b1;
    w_r_alu    = ALU_ADD;
    case (funct)
      6'b100000: w_r_alu = ALU_ADD;
      6'b100010: w_r_alu = ALU_SUB;
      6'b100100: w_r_alu = ALU_AND;
      6'b100101: w_r_alu = ALU_OR;
      6'b101010: w_r_alu = ALU_SLT;
      6'b000000: w_r_alu = ALU_SLL;
      6'b000010: w_r_alu = ALU_SRL;
      default:   w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    alu_control = ALU_ADD;
    illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          w_is_mem:               w_next = S_MEM_ADDR;
          (w_is_r && w_funct_ok): w_next = S_EXECUTE;
          w_is_beq:               w_next = S_BRANCH;
          w_is_addi:              w_next = S_ADDI_EXEC;
          w_is_j:                 w_next = S_JUMP;
          default: begin
            w_next     = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = w_is_lw ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        w_retire  = mem_ready;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = w_r_alu;
        w_next      = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write   = 1'b1;
        reg_dst     = 1'b1;
        alu_control = w_r_alu;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_source   = 2'b01;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // reset blanks every output, so an abandoned access cannot complete
    if (rst) begin
      pc_write    = 1'b0;
      branch      = 1'b0;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_source   = 2'b00;
      alu_control = 4'b0000;
      illegal_op  = 1'b0;
    end
  end

  assign pc_en       = pc_write | (branch & zero);
  assign state       = rst ? 4'd0 : r_state;
  assign instr_count = rst ? 32'd0 : r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Expected behaviour comes from per-instruction state sequences.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic        pc_write;
  logic        branch;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_source;
  logic [3:0]  alu_control;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_count;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en),
    .pc_write(pc_write), .branch(branch), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_control(alu_control),
    .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          exp_state = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_rst = 1'b1;
  bit          chk_en = 0;
  bit          ret_pend = 0;
  bit          rst_pend = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h",
               nm, cyc_n, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op,
                               input logic [5:0] fn);
    case (op)
      6'b100011, 6'b101011, 6'b000100,
      6'b001000, 6'b000010: return 1'b1;
      6'b000000: begin
        case (fn)
          6'b100000, 6'b100010, 6'b100100, 6'b100101,
          6'b101010, 6'b000000, 6'b000010: return 1'b1;
          default: return 1'b0;
        endcase
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] falu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b000000: return 4'b1100;
      6'b000010: return 4'b1101;
      default:   return 4'b0010;
    endcase
  endfunction

  // one cycle: drive inputs and publish the expected state
  task automatic cyc(input int st, input logic mr, input logic z,
                     input logic r, input bit ret);
    @(negedge clk);
    if (rst_pend) begin
      exp_cnt  = 32'd0;
      ret_pend = 0;
    end else if (ret_pend) begin
      exp_cnt  = exp_cnt + 32'd1;
      ret_pend = 0;
    end
    rst_pend  = r;
    ret_pend  = ret && !r;
    rst       = r;
    mem_ready = mr;
    zero      = z;
    exp_state = st;
    exp_rst   = r;
    chk_en    = 1;
    cyc_n++;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int fst, input int mst,
                       output int ncyc);
    int c0;
    c0 = cyc_n;
    for (int i = 0; i <= fst; i++) begin
      cyc(0, i == fst, z, 1'b0, 0);
      if (i == 0) begin
        opcode = op;
        funct  = fn;
      end
    end
    cyc(1, 1'b1, z, 1'b0, 0);
    if (legal(op, fn)) begin
      case (op)
        6'b100011: begin
          cyc(2, 1'b1, z, 1'b0, 0);
          for (int i = 0; i <= mst; i++)
            cyc(3, i == mst, z, 1'b0, 0);
          cyc(4, 1'b1, z, 1'b0, 1);
        end
        6'b101011: begin
          cyc(2, 1'b1, z, 1'b0, 0);
          for (int i = 0; i <= mst; i++)
            cyc(5, i == mst, z, 1'b0, i == mst);
        end
        6'b000000: begin
          cyc(6, 1'b0, z, 1'b0, 0);
          cyc(7, 1'b1, z, 1'b0, 1);
        end
        6'b000100: cyc(8, 1'b1, z, 1'b0, 1);
        6'b001000: begin
          cyc(9, 1'b0, z, 1'b0, 0);
          cyc(10, 1'b1, z, 1'b0, 1);
        end
        default: cyc(11, 1'b1, z, 1'b0, 1);
      endcase
    end
    ncyc = cyc_n - c0;
  endtask

  // compare process: every output against the expected state each cycle
  always @(negedge clk) begin
    logic       e_pcw, e_br, e_iod, e_mr, e_mw, e_ir, e_rd;
    logic       e_m2r, e_rw, e_sa, e_ill;
    logic [1:0] e_sb, e_ps;
    logic [3:0] e_alu, e_st;
    logic [31:0] e_cnt;
    #2;
    if (chk_en) begin
      e_pcw = 0; e_br = 0; e_iod = 0; e_mr = 0; e_mw = 0;
      e_ir = 0; e_rd = 0; e_m2r = 0; e_rw = 0; e_sa = 0;
      e_ill = 0; e_sb = 2'd0; e_ps = 2'd0; e_alu = 4'b0010;
      e_st = 4'(exp_state); e_cnt = exp_cnt;
      case (exp_state)
        0: begin
          e_mr = 1; e_sb = 2'd1;
          e_ir = mem_ready; e_pcw = mem_ready;
        end
        1: begin
          e_sb = 2'd3; e_ill = !legal(opcode, funct);
        end
        2: begin e_sa = 1; e_sb = 2'd2; end
        3: begin e_mr = 1; e_iod = 1; end
        4: begin e_rw = 1; e_m2r = 1; end
        5: begin e_mw = 1; e_iod = 1; end
        6: begin e_sa = 1; e_alu = falu(funct); end
        7: begin e_rw = 1; e_rd = 1; e_alu = falu(funct); end
        8: begin e_sa = 1; e_alu = 4'b0110; e_br = 1; e_ps = 2'd1; end
        9: begin e_sa = 1; e_sb = 2'd2; end
        10: e_rw = 1;
        11: begin e_pcw = 1; e_ps = 2'd2; end
        default: ;
      endcase
      if (exp_rst) begin
        e_pcw = 0; e_br = 0; e_iod = 0; e_mr = 0; e_mw = 0;
        e_ir = 0; e_rd = 0; e_m2r = 0; e_rw = 0; e_sa = 0;
        e_ill = 0; e_sb = 2'd0; e_ps = 2'd0; e_alu = 4'd0;
        e_st = 4'd0; e_cnt = 32'd0;
      end
      chk("pc_en", 32'(pc_en), 32'(e_pcw | (e_br & zero)));
      chk("pc_write", 32'(pc_write), 32'(e_pcw));
      chk("branch", 32'(branch), 32'(e_br));
      chk("i_or_d", 32'(i_or_d), 32'(e_iod));
      chk("mem_read", 32'(mem_read), 32'(e_mr));
      chk("mem_write", 32'(mem_write), 32'(e_mw));
      chk("ir_write", 32'(ir_write), 32'(e_ir));
      chk("reg_dst", 32'(reg_dst), 32'(e_rd));
      chk("mem_to_reg", 32'(mem_to_reg), 32'(e_m2r));
      chk("reg_write", 32'(reg_write), 32'(e_rw));
      chk("alu_src_a", 32'(alu_src_a), 32'(e_sa));
      chk("alu_src_b", 32'(alu_src_b), 32'(e_sb));
      chk("pc_source", 32'(pc_source), 32'(e_ps));
      chk("alu_control", 32'(alu_control), 32'(e_alu));
      chk("illegal_op", 32'(illegal_op), 32'(e_ill));
      chk("state", 32'(state), 32'(e_st));
      chk("instr_count", instr_count, e_cnt);
    end
  end

  int n;

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0;
    zero = 1'b0; mem_ready = 1'b0;
    cyc(0, 1'b0, 1'b0, 1'b1, 0);
    cyc(0, 1'b1, 1'b0, 1'b1, 0);

    instr(6'b000000, 6'b100000, 1'b0, 0, 0, n);
    chk("add_cycles", 32'(n), 32'd4);
    instr(6'b100011, 6'd0, 1'b0, 0, 3, n);
    chk("lw_stall_cycles", 32'(n), 32'd8);
    cyc(0, 1'b0, 1'b0, 1'b0, 0);
    #2 chk("cnt_after_lw", instr_count, 32'd2);

    instr(6'b000100, 6'd0, 1'b1, 0, 0, n);
    chk("beq_taken_cycles", 32'(n), 32'd3);
    instr(6'b000100, 6'd0, 1'b0, 0, 0, n);
    chk("beq_not_cycles", 32'(n), 32'd3);
    cyc(0, 1'b0, 1'b0, 1'b0, 0);
    #2 chk("cnt_after_beq", instr_count, 32'd4);

    instr(6'b111111, 6'd0, 1'b0, 0, 0, n);
    chk("ill_op_cycles", 32'(n), 32'd2);
    instr(6'b000000, 6'b111111, 1'b0, 0, 0, n);
    chk("ill_fn_cycles", 32'(n), 32'd2);
    cyc(0, 1'b0, 1'b0, 1'b0, 0);
    #2 chk("cnt_after_ill", instr_count, 32'd4);

    instr(6'b000000, 6'b100010, 1'b0, 0, 0, n);
    instr(6'b000000, 6'b100100, 1'b0, 0, 0, n);
    instr(6'b000000, 6'b100101, 1'b0, 1, 0, n);
    instr(6'b000000, 6'b101010, 1'b0, 0, 0, n);
    instr(6'b000000, 6'b000000, 1'b0, 0, 0, n);
    instr(6'b000000, 6'b000010, 1'b0, 0, 0, n);
    instr(6'b101011, 6'd0, 1'b0, 2, 1, n);
    chk("sw_stall_cycles", 32'(n), 32'd7);
    instr(6'b001000, 6'd0, 1'b0, 0, 0, n);
    chk("addi_cycles", 32'(n), 32'd4);
    cyc(0, 1'b0, 1'b0, 1'b0, 0);
    #2 chk("cnt_after_mix", instr_count, 32'd12);

    // reset while a store is waiting on memory
    cyc(0, 1'b1, 1'b0, 1'b0, 0);
    opcode = 6'b101011;
    cyc(1, 1'b1, 1'b0, 1'b0, 0);
    cyc(2, 1'b1, 1'b0, 1'b0, 0);
    cyc(5, 1'b0, 1'b0, 1'b0, 0);
    cyc(5, 1'b0, 1'b0, 1'b1, 0);
    #2 chk("mw_in_reset", 32'(mem_write), 32'd0);
    cyc(0, 1'b0, 1'b0, 1'b0, 0);
    #2 chk("cnt_after_rst", instr_count, 32'd0);
    cyc(0, 1'b0, 1'b0, 1'b0, 0);
    #2 chk("state_after_rst", 32'(state), 32'd0);

    // wrap the counter on a jump
    force dut.r_count = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    cyc(0, 1'b0, 1'b0, 1'b0, 0);
    release dut.r_count;
    #2 chk("cnt_preload", instr_count, 32'hFFFF_FFFF);
    instr(6'b000010, 6'd0, 1'b0, 0, 0, n);
    chk("j_cycles", 32'(n), 32'd3);
    cyc(0, 1'b0, 1'b0, 1'b0, 0);
    #2 chk("cnt_wrap", instr_count, 32'd0);

    @(negedge clk);
    chk_en = 0;
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
